// File: rtl/mac_out_collector.sv
// Purpose: buffers MAC accumulator vectors in a small FIFO and serialises each one
//          onto a narrower valid/ready beat bus.
// Latency: a vector strobed in cycle T presents beat 0 with out_valid_o=1 in T+1.
// Backpressure: the output stalls on out_ready_i=0 and holds the beat stable.
//          The input has no backpressure, so a strobe into a full FIFO is dropped
//          and sets the sticky overflow_o flag. space_ok_o lets the controller
//          throttle new MAC issues before that happens.
//
// Ports:
//   clk, nrst       clock, synchronous active-low reset
//   clear_i         synchronous flush, same effect as reset
//   acc_valid_i     single-cycle strobe qualifying acc_data_i
//   acc_data_i      full output vector, element i at [i*outputBits +: outputBits]
//   space_ok_o      free entries > reserveSlots
//   out_valid_o     beat valid; out_ready_i is the consumer ready
//   out_data_o      beat payload, lane j = element beat*lanesPerBeat + j
//   out_beat_o      beat index within the current vector
//   out_last_o      final beat of a vector
//   count_o         stored vectors, including the one being sent
//   overflow_o      sticky, set when a vector was dropped
module mac_out_collector #(
   parameter int outputElements = 32,
   parameter int outputBits     = 4,
   parameter int lanesPerBeat   = 8,
   parameter int fifoDepth      = 4,
   parameter int reserveSlots   = 2
) (
   input  logic                                             clk,
   input  logic                                             nrst,
   input  logic                                             clear_i,
   input  logic                                             acc_valid_i,
   input  logic [outputElements*outputBits-1:0]             acc_data_i,
   output logic                                             space_ok_o,
   output logic                                             out_valid_o,
   input  logic                                             out_ready_i,
   output logic [lanesPerBeat*outputBits-1:0]               out_data_o,
   output logic [$clog2(outputElements/lanesPerBeat)-1:0]   out_beat_o,
   output logic                                             out_last_o,
   output logic [$clog2(fifoDepth+1)-1:0]                   count_o,
   output logic                                             overflow_o
);

   localparam int BEATS = outputElements / lanesPerBeat;
   localparam int VW    = outputElements * outputBits;
   localparam int LW    = lanesPerBeat * outputBits;
   localparam int BW    = $clog2(BEATS);
   localparam int PW    = $clog2(fifoDepth);
   localparam int CW    = $clog2(fifoDepth + 1);

   typedef enum logic {IDLE, SEND} state_t;

   logic [VW-1:0] mem_q [fifoDepth];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   state_t        state_q;
   logic          valid_q;
   logic [BW-1:0] beat_q;
   logic          overflow_q;

   logic last_beat;
   logic hs;
   logic pop;
   logic push;
   logic drop;

   assign last_beat = (beat_q == BW'(BEATS - 1));
   assign hs        = valid_q & out_ready_i;
   assign pop       = hs & last_beat;
   // A full FIFO still accepts a vector when the head leaves in the same cycle.
   assign push      = acc_valid_i & ((count_q != CW'(fifoDepth)) | pop);
   assign drop      = acc_valid_i & ~push;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Storage carries no reset: an entry is only read after it has been written.
   // A clear in the same cycle as a strobe leaves the written slot unreferenced.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= acc_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst || clear_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         beat_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_d;
         if (drop) begin
            overflow_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               // Look at next-state count so beat 0 appears one cycle after the strobe.
               if (count_d != '0) begin
                  state_q <= SEND;
                  valid_q <= 1'b1;
                  beat_q  <= '0;
               end
            end
            SEND: begin
               if (hs) begin
                  if (last_beat) begin
                     beat_q <= '0;
                     // Remaining vectors follow with no idle cycle.
                     if (count_d == '0) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                     end
                  end else begin
                     beat_q <= beat_q + BW'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid_o = valid_q;
   assign out_beat_o  = beat_q;
   assign out_last_o  = valid_q & last_beat;
   assign out_data_o  = mem_q[rd_ptr_q][beat_q*LW +: LW];
   assign count_o     = count_q;
   assign overflow_o  = overflow_q;
   assign space_ok_o  = (fifoDepth - int'(count_q)) > reserveSlots;

endmodule
